// File: rtl/key_decoder_if.sv
// Key-byte bus between the stdin reader/controller and the key decoder.
// The decoder takes the slave side: it receives the raw byte and drives the control events.
interface key_decoder_if #(
   parameter int unsigned CNT_W = 16
);
   logic [7:0]       inp;
   logic             flap;
   logic             paused;
   logic             quit;
   logic             err;
   logic [CNT_W-1:0] flap_cnt;

   modport master (
      output inp,
      input  flap, paused, quit, err, flap_cnt
   );

   modport slave (
      input  inp,
      output flap, paused, quit, err, flap_cnt
   );
endinterface

// File: rtl/key_decoder.sv
// Registered key-byte decoder: single-key controls plus ESC [ A parsing into flap/pause/quit/err events.
// Every output is a flop; inp only reaches the outputs through a clock edge.
module key_decoder #(
   parameter int unsigned HOLD_CYCLES = 5,
   parameter int unsigned ESC_TIMEOUT = 3,
   parameter int unsigned CNT_W       = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   key_decoder_if.slave bus
);

   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned TO_W   = $clog2(ESC_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ESC  = 2'd1;
   localparam logic [1:0] S_CSI  = 2'd2;

   localparam logic [7:0] K_SPACE = 8'h20;
   localparam logic [7:0] K_ESC   = 8'h1B;
   localparam logic [7:0] K_LBRK  = 8'h5B;
   localparam logic [7:0] K_P_LO  = 8'h70;
   localparam logic [7:0] K_P_UP  = 8'h50;
   localparam logic [7:0] K_Q_LO  = 8'h71;
   localparam logic [7:0] K_Q_UP  = 8'h51;
   localparam logic [7:0] K_UP    = 8'h41;
   localparam logic [7:0] K_DOWN  = 8'h42;
   localparam logic [7:0] K_RIGHT = 8'h43;
   localparam logic [7:0] K_LEFT  = 8'h44;

   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ESC_TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [1:0]        state, state_nxt;
   logic [TO_W-1:0]   to_cnt, to_nxt;
   logic [HOLD_W-1:0] hold, hold_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              flap_q, flap_nxt;
   logic              paused_q, paused_nxt;
   logic              quit_q, quit_nxt;
   logic              err_q, err_nxt;
   logic              flap_ev;
   logic              valid;
   logic              timed_out;

   assign valid     = (bus.inp != 8'h00) && (bus.inp != 8'hFF);
   assign timed_out = !valid && (to_cnt == TO_LAST);

   // State and event register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         to_cnt   <= '0;
         hold     <= '0;
         cnt      <= '0;
         flap_q   <= 1'b0;
         paused_q <= 1'b0;
         quit_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         to_cnt   <= to_nxt;
         hold     <= hold_nxt;
         cnt      <= cnt_nxt;
         flap_q   <= flap_nxt;
         paused_q <= paused_nxt;
         quit_q   <= quit_nxt;
         err_q    <= err_nxt;
      end
   end

   // Parser next state and event decode; idle bytes only advance the timeout
   always_comb begin
      state_nxt  = state;
      to_nxt     = to_cnt;
      quit_nxt   = 1'b0;
      err_nxt    = 1'b0;
      paused_nxt = paused_q;
      flap_ev    = 1'b0;

      case (state)
         S_IDLE: begin
            to_nxt = '0;
            if (valid) begin
               case (bus.inp)
                  K_SPACE:        flap_ev    = 1'b1;
                  K_P_LO, K_P_UP: paused_nxt = !paused_q;
                  K_Q_LO, K_Q_UP: quit_nxt   = 1'b1;
                  K_ESC:          state_nxt  = S_ESC;
                  default:        ;
               endcase
            end
         end

         S_ESC: begin
            if (valid) begin
               to_nxt = '0;
               if (bus.inp == K_LBRK) begin
                  state_nxt = S_CSI;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = S_IDLE;
               end
            end else if (timed_out) begin
               quit_nxt  = 1'b1;
               to_nxt    = '0;
               state_nxt = S_IDLE;
            end else begin
               to_nxt = to_cnt + TO_W'(1);
            end
         end

         S_CSI: begin
            if (valid) begin
               to_nxt    = '0;
               state_nxt = S_IDLE;
               case (bus.inp)
                  K_UP:                   flap_ev = 1'b1;
                  K_DOWN, K_RIGHT, K_LEFT: ;
                  default:                err_nxt = 1'b1;
               endcase
            end else if (timed_out) begin
               err_nxt   = 1'b1;
               to_nxt    = '0;
               state_nxt = S_IDLE;
            end else begin
               to_nxt = to_cnt + TO_W'(1);
            end
         end

         default: begin
            to_nxt    = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Hold window and event counter; a reload beats the decrement, paused drops the event
   always_comb begin
      hold_nxt = (hold == '0) ? '0 : hold - HOLD_W'(1);
      cnt_nxt  = cnt;
      if (flap_ev && !paused_q) begin
         hold_nxt = HOLD_LOAD;
         if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
      flap_nxt = (hold_nxt != '0);
   end

   assign bus.flap     = flap_q;
   assign bus.paused   = paused_q;
   assign bus.quit     = quit_q;
   assign bus.err      = err_q;
   assign bus.flap_cnt = cnt;

endmodule

// File: tb/tb_key_decoder.sv
// Directed bench for key_decoder with HOLD_CYCLES=5, ESC_TIMEOUT=3 and a 4-bit counter.
module tb_key_decoder;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   key_decoder_if #(.CNT_W(4)) bus ();

   key_decoder #(
      .HOLD_CYCLES (5),
      .ESC_TIMEOUT (3),
      .CNT_W       (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one byte, let one edge sample it, then settle 1 time unit past the edge.
   task automatic tick(input logic [7:0] b);
      bus.inp = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.inp  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_flap",   32'(bus.flap),     32'd0);
      chk("rst_paused", 32'(bus.paused),   32'd0);
      chk("rst_quit",   32'(bus.quit),     32'd0);
      chk("rst_err",    32'(bus.err),      32'd0);
      chk("rst_cnt",    32'(bus.flap_cnt), 32'd0);
      rst_n = 1'b1;
      tick(8'h00);
      tick(8'h00);

      // Space then retrigger three cycles later
      tick(8'h20);
      chk("sp1_flap", 32'(bus.flap),     32'd1);
      chk("sp1_cnt",  32'(bus.flap_cnt), 32'd1);
      tick(8'h00);
      tick(8'h00);
      chk("sp1_hold2", 32'(bus.flap), 32'd1);
      tick(8'h20);
      chk("sp2_flap", 32'(bus.flap),     32'd1);
      chk("sp2_cnt",  32'(bus.flap_cnt), 32'd2);
      tick(8'h00);
      tick(8'h00);
      chk("retrig_gap", 32'(bus.flap), 32'd1);
      tick(8'h00);
      tick(8'h00);
      chk("retrig_last", 32'(bus.flap), 32'd1);
      tick(8'h00);
      chk("retrig_fall", 32'(bus.flap), 32'd0);

      // ESC [ A flaps; ESC [ B is silent
      tick(8'h1B);
      tick(8'h5B);
      chk("csi_a_pre", 32'(bus.flap), 32'd0);
      tick(8'h41);
      chk("csi_a_flap", 32'(bus.flap),     32'd1);
      chk("csi_a_cnt",  32'(bus.flap_cnt), 32'd3);
      chk("csi_a_err",  32'(bus.err),      32'd0);
      repeat (4) tick(8'h00);
      chk("csi_a_last", 32'(bus.flap), 32'd1);
      tick(8'h00);
      chk("csi_a_fall", 32'(bus.flap), 32'd0);
      tick(8'h1B);
      tick(8'h5B);
      tick(8'h42);
      chk("csi_b_flap", 32'(bus.flap),     32'd0);
      chk("csi_b_err",  32'(bus.err),      32'd0);
      chk("csi_b_cnt",  32'(bus.flap_cnt), 32'd3);

      // Lone ESC times out into quit on the third idle cycle
      tick(8'h1B);
      tick(8'h00);
      tick(8'h00);
      chk("esc_to_early", 32'(bus.quit), 32'd0);
      tick(8'h00);
      chk("esc_to_quit", 32'(bus.quit), 32'd1);
      tick(8'h00);
      chk("esc_to_fall", 32'(bus.quit), 32'd0);

      // ESC followed by junk: err, byte discarded, parser idle again
      tick(8'h1B);
      tick(8'h78);
      chk("esc_x_err",  32'(bus.err),  32'd1);
      chk("esc_x_quit", 32'(bus.quit), 32'd0);
      tick(8'h00);
      chk("esc_x_errfall", 32'(bus.err), 32'd0);
      tick(8'h20);
      chk("esc_x_flap", 32'(bus.flap),     32'd1);
      chk("esc_x_cnt",  32'(bus.flap_cnt), 32'd4);
      repeat (5) tick(8'h00);
      chk("esc_x_drain", 32'(bus.flap), 32'd0);

      // Pause drops flap events; quit passes through while paused
      tick(8'h70);
      chk("pause_on", 32'(bus.paused), 32'd1);
      tick(8'h20);
      chk("paused_flap", 32'(bus.flap),     32'd0);
      chk("paused_cnt",  32'(bus.flap_cnt), 32'd4);
      tick(8'h50);
      chk("pause_off", 32'(bus.paused), 32'd0);
      tick(8'h20);
      chk("unpaused_flap", 32'(bus.flap),     32'd1);
      chk("unpaused_cnt",  32'(bus.flap_cnt), 32'd5);
      tick(8'h70);
      tick(8'h71);
      chk("q_paused_quit",   32'(bus.quit),   32'd1);
      chk("q_paused_paused", 32'(bus.paused), 32'd1);
      chk("q_paused_cnt",    32'(bus.flap_cnt), 32'd5);
      tick(8'h00);
      chk("q_paused_fall", 32'(bus.quit), 32'd0);
      tick(8'h50);
      tick(8'h00);
      chk("pause_drain", 32'(bus.flap), 32'd0);

      // Short idle gaps inside the sequence are tolerated
      tick(8'h1B);
      tick(8'hFF);
      tick(8'h00);
      tick(8'h5B);
      tick(8'h00);
      tick(8'hFF);
      chk("gap_pre", 32'(bus.flap), 32'd0);
      tick(8'h41);
      chk("gap_flap", 32'(bus.flap),     32'd1);
      chk("gap_cnt",  32'(bus.flap_cnt), 32'd6);
      chk("gap_err",  32'(bus.err),      32'd0);

      // CSI left hanging times out as err
      tick(8'h1B);
      tick(8'h5B);
      tick(8'h00);
      tick(8'h00);
      chk("csi_to_early", 32'(bus.err), 32'd0);
      tick(8'h00);
      chk("csi_to_err",  32'(bus.err),  32'd1);
      chk("csi_to_quit", 32'(bus.quit), 32'd0);

      // Counter saturates at 15 while flap keeps firing
      repeat (9) tick(8'h20);
      chk("sat_reach", 32'(bus.flap_cnt), 32'd15);
      repeat (6) tick(8'h00);
      chk("sat_idle", 32'(bus.flap), 32'd0);
      tick(8'h20);
      chk("sat_hold", 32'(bus.flap_cnt), 32'd15);
      chk("sat_flap", 32'(bus.flap),     32'd1);

      // Async reset while in CSI with flap high and paused set
      tick(8'h70);
      tick(8'h1B);
      tick(8'h5B);
      chk("pre_rst_flap",   32'(bus.flap),   32'd1);
      chk("pre_rst_paused", 32'(bus.paused), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_flap",   32'(bus.flap),     32'd0);
      chk("mid_rst_paused", 32'(bus.paused),   32'd0);
      chk("mid_rst_cnt",    32'(bus.flap_cnt), 32'd0);
      chk("mid_rst_quit",   32'(bus.quit),     32'd0);
      bus.inp = 8'h00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(8'h41);
      chk("post_rst_flap", 32'(bus.flap),     32'd0);
      chk("post_rst_err",  32'(bus.err),      32'd0);
      chk("post_rst_cnt",  32'(bus.flap_cnt), 32'd0);
      tick(8'h00);
      chk("post_rst_quit", 32'(bus.quit), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_decoder.md
# key_decoder

Registered input-decode stage between the stdin byte reader and the game controller. It consumes the raw per-cycle key byte and turns it into clean control events: a retriggerable flap level, a pause toggle, a quit pulse and an error pulse. It also parses the ANSI cursor-up sequence ESC [ A as an alternative flap key. The controller consumes `flap` in place of its own key-press shift buffer.

## Interface
- HOLD_CYCLES, 5: number of cycles `flap` stays high after a flap event.
- ESC_TIMEOUT, 3: idle cycles after a lone ESC before it is taken as quit.
- CNT_W, 16: width of the flap event counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- inp  in  8  key byte sampled each cycle; 0x00 and 0xFF (EOF) mean "no byte".
- flap  out  1  high while the hold counter is nonzero.
- paused  out  1  pause state level.
- quit  out  1  one-cycle pulse.
- err  out  1  one-cycle pulse on a malformed escape sequence.
- flap_cnt  out  CNT_W  accepted flap events, saturating at all-ones.

## Operation
- Byte classes:
  - "valid byte" means inp ∉ {0x00, 0xFF}.
  - Idle cycles (non-valid bytes) never change parser state, except by advancing the timeout counter.
- Parser FSM states: IDLE, ESC, CSI.
  - IDLE, byte 0x20 (space): flap event.
  - IDLE, byte 'p'/'P': toggle `paused`.
  - IDLE, byte 'q'/'Q': quit.
  - IDLE, byte 0x1B: go to ESC and clear the timeout counter.
  - IDLE, any other valid byte: ignored.
  - ESC, byte '[' (0x5B): go to CSI and clear the timeout counter.
  - ESC, any other valid byte: err, go to IDLE. The byte is discarded, not reinterpreted.
  - ESC, ESC_TIMEOUT consecutive idle cycles: quit (lone ESC), go to IDLE.
  - CSI, byte 'A': flap event, go to IDLE.
  - CSI, byte 'B', 'C' or 'D': silently accepted, go to IDLE.
  - CSI, any other valid byte: err, go to IDLE.
  - CSI, ESC_TIMEOUT consecutive idle cycles: err, go to IDLE.
- Flap event handling:
  - While `paused`=0: load the hold counter with HOLD_CYCLES (retrigger: reload even when nonzero) and increment flap_cnt unless it is saturated.
  - While `paused`=1: the event is dropped; no counter load, no increment.
- Hold counter decrements by 1 each cycle while nonzero and not being reloaded. A reload takes priority over the decrement.
- Quit is accepted regardless of `paused`. Quit does not change `paused` or any counter.
- Simultaneous events: at most one byte arrives per cycle, so only one event fires per cycle. A timeout and a valid byte in the same cycle cannot occur, because timeout counts idle cycles only.
- Reset values:
  - State: IDLE.
  - flap=0, paused=0, quit=0, err=0, flap_cnt=0.
  - Hold counter and timeout counter: 0.
- Reset mid-sequence, e.g. in ESC or CSI: everything returns to the reset values immediately; no quit or err is emitted.

## Timing
- All outputs are registered.
- Byte sampled at edge n:
  - quit, err, `paused` toggle and flap_cnt update are visible after edge n, for the cycle n..n+1.
  - quit and err fall after edge n+1 unless re-fired.
- flap: first high after edge n, stays high for exactly HOLD_CYCLES cycles, low after edge n+HOLD_CYCLES, absent retrigger.
- Retrigger at edge m while high: flap remains high through edge m+HOLD_CYCLES, with no low gap.
- Lone ESC at edge n, followed by idle cycles: quit pulses after edge n+ESC_TIMEOUT.
- ESC [ A bytes at edges n, n+1, n+2:
  - flap rises after edge n+2.
  - Idle gaps shorter than ESC_TIMEOUT between the bytes are tolerated and delay the result accordingly.
- Latency from input byte to output: one cycle for every event; no combinational path from inp to any output.

## Test plan
- Space at cycle 10, then idle → flap high for cycles 11–15 (HOLD_CYCLES=5), flap_cnt=1; a second space at 13 → flap stays high through cycle 18, flap_cnt=2.
- Bytes 0x1B, 0x5B, 0x41 on three consecutive cycles → one flap window starting the cycle after 'A', no err, flap_cnt increments by 1; 0x1B, 0x5B, 0x42 → no flap, no err.
- 0x1B then 0x00 for 3 cycles → single quit pulse on the 3rd cycle after ESC; 0x1B, 'x' → err pulse, parser back in IDLE, and a subsequent space flaps normally.
- 'p', then space, then 'P', then space → paused 1 then 0; the first space gives no flap and no count, the second space flaps with flap_cnt=1; 'q' while paused → quit pulse, paused unchanged.
- Inject 0xFF and 0x00 bytes between ESC and '[' (fewer than 3) → sequence still completes as a flap; flap_cnt preloaded near max via 2^CNT_W−1 events (CNT_W=4: 15) → 16th event holds the count at 15 and flap still fires.
- Assert rst_n low while in CSI with flap high → flap, paused, flap_cnt and quit go to 0 immediately; after release, a trailing 'A' is ignored (IDLE state) with no err.
